// File: rtl/vdf_iteration_sequencer.sv
// Sequences one VDF job: launches the external modular squarer, counts its completions,
// and reports the captured result with an OK / TIMEOUT / ABORTED / BAD_T status.
module vdf_iteration_sequencer #(
    parameter int MOD_LEN      = 1024,
    parameter int WORD_LEN     = 16,
    parameter int NUM_ELEMENTS = MOD_LEN / WORD_LEN + 1,
    parameter int SQ_OUT_BITS  = NUM_ELEMENTS * WORD_LEN * 2,
    parameter int T_LEN        = 64,
    parameter int TIMEOUT      = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [MOD_LEN-1:0]     job_x,
    input  logic [T_LEN-1:0]       job_t,
    input  logic                   abort,
    output logic                   msq_reset,
    output logic                   msq_start,
    output logic [MOD_LEN-1:0]     msq_in,
    input  logic [SQ_OUT_BITS-1:0] msq_out,
    input  logic                   msq_valid,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [SQ_OUT_BITS-1:0] res_data,
    output logic [1:0]             res_status,
    output logic [T_LEN-1:0]       iter_count
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] STATUS_OK      = 2'd0;
    localparam logic [1:0] STATUS_TIMEOUT = 2'd1;
    localparam logic [1:0] STATUS_ABORTED = 2'd2;
    localparam logic [1:0] STATUS_BAD_T   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LAUNCH,
        RUN,
        DONE
    } state_t;

    state_t                 state_reg;
    logic [T_LEN-1:0]       job_t_reg;
    logic [WD_W-1:0]        watchdog_reg;
    logic                   job_ready_reg;
    logic                   msq_reset_reg;
    logic                   msq_start_reg;
    logic [MOD_LEN-1:0]     msq_in_reg;
    logic                   res_valid_reg;
    logic [SQ_OUT_BITS-1:0] res_data_reg;
    logic [1:0]             res_status_reg;
    logic [T_LEN-1:0]       iter_count_reg;

    logic last_iter;
    logic wd_expired;

    assign last_iter  = (iter_count_reg == job_t_reg - T_LEN'(1));
    assign wd_expired = (watchdog_reg >= WD_W'(TIMEOUT - 1));

    assign job_ready  = job_ready_reg;
    assign msq_reset  = msq_reset_reg;
    assign msq_start  = msq_start_reg;
    assign msq_in     = msq_in_reg;
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_status = res_status_reg;
    assign iter_count = iter_count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            job_t_reg      <= '0;
            watchdog_reg   <= '0;
            job_ready_reg  <= 1'b1;
            msq_reset_reg  <= 1'b1;
            msq_start_reg  <= 1'b0;
            msq_in_reg     <= '0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_status_reg <= STATUS_OK;
            iter_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (job_valid && job_ready_reg) begin
                        job_ready_reg  <= 1'b0;
                        iter_count_reg <= '0;
                        if (job_t == '0) begin
                            // Zero-length job is rejected without touching the squarer.
                            state_reg      <= DONE;
                            res_valid_reg  <= 1'b1;
                            res_status_reg <= STATUS_BAD_T;
                            res_data_reg   <= '0;
                        end else begin
                            state_reg     <= ARM;
                            msq_in_reg    <= job_x;
                            job_t_reg     <= job_t;
                            msq_reset_reg <= 1'b0;
                        end
                    end
                end

                ARM, LAUNCH, RUN: begin
                    if (abort) begin
                        state_reg      <= DONE;
                        msq_reset_reg  <= 1'b1;
                        msq_start_reg  <= 1'b0;
                        res_valid_reg  <= 1'b1;
                        res_status_reg <= STATUS_ABORTED;
                        res_data_reg   <= '0;
                    end else if (state_reg == ARM) begin
                        state_reg     <= LAUNCH;
                        msq_start_reg <= 1'b1;
                    end else if (state_reg == LAUNCH) begin
                        // Watchdog holds cycles elapsed since the last event, so the
                        // cycle after an event already counts as one.
                        state_reg     <= RUN;
                        msq_start_reg <= 1'b0;
                        watchdog_reg  <= WD_W'(1);
                    end else if (msq_valid) begin
                        watchdog_reg <= WD_W'(1);
                        if (last_iter) begin
                            state_reg      <= DONE;
                            msq_reset_reg  <= 1'b1;
                            res_valid_reg  <= 1'b1;
                            res_status_reg <= STATUS_OK;
                            res_data_reg   <= msq_out;
                            iter_count_reg <= job_t_reg;
                        end else begin
                            iter_count_reg <= iter_count_reg + T_LEN'(1);
                        end
                    end else if (wd_expired) begin
                        state_reg      <= DONE;
                        msq_reset_reg  <= 1'b1;
                        res_valid_reg  <= 1'b1;
                        res_status_reg <= STATUS_TIMEOUT;
                        res_data_reg   <= '0;
                    end else begin
                        watchdog_reg <= watchdog_reg + WD_W'(1);
                    end
                end

                DONE: begin
                    if (res_ready) begin
                        state_reg     <= IDLE;
                        res_valid_reg <= 1'b0;
                        job_ready_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vdf_iteration_sequencer.sv
// Scoreboard bench for vdf_iteration_sequencer: a squarer model answers the DUT,
// an event-level reference predicts each job outcome, and a monitor checks results.
module tb_vdf_iteration_sequencer;
    localparam int MOD_LEN      = 32;
    localparam int WORD_LEN     = 8;
    localparam int NUM_ELEMENTS = MOD_LEN / WORD_LEN + 1;
    localparam int SQ_OUT_BITS  = NUM_ELEMENTS * WORD_LEN * 2;
    localparam int T_LEN        = 8;
    localparam int TIMEOUT      = 16;

    logic                   clk;
    logic                   reset;
    logic                   job_valid;
    logic                   job_ready;
    logic [MOD_LEN-1:0]     job_x;
    logic [T_LEN-1:0]       job_t;
    logic                   abort;
    logic                   msq_reset;
    logic                   msq_start;
    logic [MOD_LEN-1:0]     msq_in;
    logic [SQ_OUT_BITS-1:0] msq_out;
    logic                   msq_valid;
    logic                   res_valid;
    logic                   res_ready;
    logic [SQ_OUT_BITS-1:0] res_data;
    logic [1:0]             res_status;
    logic [T_LEN-1:0]       iter_count;

    typedef struct {
        logic [1:0]             status;
        logic [SQ_OUT_BITS-1:0] data;
        int                     iter;
        int                     done;
        int                     starts;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    int                     sq_period = 4;
    int                     sq_limit = 0;
    logic                   sq_valid = 1'b0;
    logic                   stray_valid = 1'b0;
    logic                   sq_active = 1'b0;
    int                     sq_next = 0;
    int                     sq_k = 0;
    logic [SQ_OUT_BITS-1:0] sq_cur = '0;

    bit                     prev_rv = 1'b0;
    int                     start_cnt = 0;
    logic [1:0]             held_status;
    logic [SQ_OUT_BITS-1:0] held_data;
    logic [T_LEN-1:0]       held_iter;

    assign msq_valid = sq_valid | stray_valid;

    vdf_iteration_sequencer #(
        .MOD_LEN     (MOD_LEN),
        .WORD_LEN    (WORD_LEN),
        .NUM_ELEMENTS(NUM_ELEMENTS),
        .SQ_OUT_BITS (SQ_OUT_BITS),
        .T_LEN       (T_LEN),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .job_valid (job_valid),
        .job_ready (job_ready),
        .job_x     (job_x),
        .job_t     (job_t),
        .abort     (abort),
        .msq_reset (msq_reset),
        .msq_start (msq_start),
        .msq_in    (msq_in),
        .msq_out   (msq_out),
        .msq_valid (msq_valid),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_status(res_status),
        .iter_count(iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_bench();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Outcome from event times: launch 2 cycles after handshake, valid k at launch+k*p,
    // a gap of TIMEOUT cycles without a valid ends the job, abort wins while still busy.
    function automatic exp_t predict(input logic [MOD_LEN-1:0] x, input int t, input int p,
                                     input int n, input int a_abs, input int h);
        exp_t e;
        int launch, ev, k, nv;
        bit fin;
        logic [SQ_OUT_BITS-1:0] r;
        launch = h + 2;
        ev = launch;
        k = 0;
        fin = 1'b0;
        r = SQ_OUT_BITS'(x);
        e.status = 2'd0;
        e.data = '0;
        e.iter = 0;
        e.done = 0;
        e.starts = 1;
        if (t == 0) begin
            e.status = 2'd3;
            e.done = h + 1;
            e.starts = 0;
            return e;
        end
        while (!fin) begin
            if (k < n && p < TIMEOUT) begin
                ev = ev + p;
                k++;
                r = r * r;
                if (k == t) begin
                    e.status = 2'd0;
                    e.data = r;
                    e.done = ev + 1;
                    fin = 1'b1;
                end
            end else begin
                e.status = 2'd1;
                e.done = ev + TIMEOUT;
                fin = 1'b1;
            end
        end
        e.iter = k;
        if (a_abs > h && a_abs < e.done) begin
            nv = 0;
            for (int j = 1; j <= k; j++) if (launch + p * j < a_abs) nv++;
            e.status = 2'd2;
            e.data = '0;
            e.iter = nv;
            e.done = a_abs + 1;
            if (a_abs == h + 1) e.starts = 0;
        end
        return e;
    endfunction

    // Squarer model: captures msq_in on start, squares it every sq_period cycles.
    initial begin : squarer
        msq_out = '0;
        forever begin
            @(negedge clk);
            if (msq_start && reset) begin
                sq_active = 1'b1;
                sq_cur = SQ_OUT_BITS'(msq_in);
                sq_next = cyc + sq_period;
                sq_k = 0;
            end
            @(posedge clk);
            #1;
            sq_valid = 1'b0;
            if (msq_reset) sq_active = 1'b0;
            if (sq_active && cyc == sq_next && sq_k < sq_limit) begin
                sq_cur = sq_cur * sq_cur;
                msq_out = sq_cur;
                sq_valid = 1'b1;
                sq_k++;
                sq_next = sq_next + sq_period;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_rv = 1'b0;
                start_cnt = 0;
            end else begin
                if (msq_start) start_cnt++;
                if (res_valid && !prev_rv) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_res_valid", res_valid, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_status", res_status, e.status);
                        check("res_data", res_data, e.data);
                        check("iter_count", iter_count, e.iter);
                        check("done_cycle", cyc, e.done);
                        check("msq_start_pulses", start_cnt, e.starts);
                        check("msq_reset_in_done", msq_reset, 1);
                        $display("result: status=%0d iter=%0d data=%0h cycle=%0d", res_status,
                                 iter_count, res_data, cyc);
                    end
                    start_cnt = 0;
                    held_status = res_status;
                    held_data = res_data;
                    held_iter = iter_count;
                    check("job_ready_in_done", job_ready, 0);
                end else if (res_valid) begin
                    check("status_stable", res_status, held_status);
                    check("data_stable", res_data, held_data);
                    check("iter_stable", iter_count, held_iter);
                    check("job_ready_in_done", job_ready, 0);
                end
                prev_rv = res_valid;
            end
        end
    end

    task automatic do_handshake(input logic [MOD_LEN-1:0] x, input int t, output int h);
        h = -1;
        for (int i = 0; i < 50 && h < 0; i++) begin
            @(posedge clk);
            #1;
            job_valid = 1'b1;
            job_x = x;
            job_t = T_LEN'(t);
            @(negedge clk);
            if (job_ready) h = cyc;
        end
        if (h < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL handshake_timeout: got job_ready=0 for 50 cycles, expected 1");
            finish_bench();
        end
    endtask

    task automatic run_job(input logic [MOD_LEN-1:0] x, input int t, input int p, input int n,
                           input int abort_rel, input int hold);
        int h, a_abs;
        bit got;
        sq_period = p;
        sq_limit = n;
        do_handshake(x, t, h);
        a_abs = (abort_rel > 0) ? h + abort_rel : -1;
        exp_q.push_back(predict(x, t, p, n, a_abs, h));
        $display("job: x=%0h t=%0d period=%0d valids=%0d abort_at=%0d hold=%0d", x, t, p, n,
                 a_abs, hold);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge clk);
            #1;
            job_valid = 1'b0;
            abort = (cyc == a_abs);
            @(negedge clk);
            if (res_valid && cyc > a_abs) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL res_valid_timeout: got no res_valid, expected one within 3000 cycles");
            finish_bench();
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            abort = 1'b0;
            job_valid = 1'($urandom_range(0, 1));
            job_x = $urandom;
            job_t = T_LEN'($urandom_range(0, 5));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        res_ready = 1'b1;
        job_valid = 1'b1;
        job_t = T_LEN'(1);
        @(negedge clk);
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        job_valid = 1'b0;
        @(negedge clk);
        check("res_valid_cleared", res_valid, 0);
        check("job_ready_after_done", job_ready, 1);
    endtask

    initial begin : timeout_guard
        #800000;
        n_cmp++;
        n_err++;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        finish_bench();
    end

    initial begin : stimulus
        int h, t, p, n, a, hold;
        bit got;
        reset = 1'b0;
        job_valid = 1'b0;
        job_x = '0;
        job_t = '0;
        abort = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_job_ready", job_ready, 1);
        check("rst_msq_reset", msq_reset, 1);
        check("rst_msq_start", msq_start, 0);
        check("rst_msq_in", msq_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_status", res_status, 0);
        check("rst_iter_count", iter_count, 0);

        run_job(32'd3, 5, 4, 5, -1, 1);
        run_job(32'h0000_1234, 0, 4, 0, -1, 1);
        run_job(32'h0000_0007, 10, 4, 3, -1, 0);
        run_job(32'h0000_0005, 4, 4, 4, 2 + 4 * 4, 0);

        // Reset pulse in the middle of a running job.
        sq_period = 4;
        sq_limit = 10;
        do_handshake(32'h1234_5677, 10, h);
        $display("job: reset mid-run, t=10 handshake cycle=%0d", h);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk);
            #1;
            job_valid = 1'b0;
            @(negedge clk);
            if (iter_count == T_LEN'(2)) got = 1'b1;
        end
        check("iter_reached_2", got, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrun_rst_job_ready", job_ready, 1);
        check("midrun_rst_msq_reset", msq_reset, 1);
        check("midrun_rst_res_valid", res_valid, 0);
        check("midrun_rst_iter", iter_count, 0);
        @(posedge clk);
        #1;
        stray_valid = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        stray_valid = 1'b0;
        @(negedge clk);
        check("idle_ignores_valid", iter_count, 0);
        run_job(32'h0000_0009, 2, 3, 2, -1, 0);

        run_job(32'h0000_000b, 3, 5, 3, -1, 20);
        run_job(32'h0000_000d, 2, TIMEOUT - 1, 2, -1, 0);
        run_job(32'h0000_000f, 2, TIMEOUT, 2, -1, 0);
        run_job(32'h0000_0011, 3, 3, 3, 1, 0);
        run_job(32'h0000_0013, 3, 3, 3, 2, 0);
        run_job(32'h0000_0015, 255, 1, 255, -1, 0);

        for (int j = 0; j < 30; j++) begin
            t = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            p = $urandom_range(1, 17);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, t)) : t;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : -1;
            hold = $urandom_range(0, 3);
            run_job($urandom, t, p, n, a, hold);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        finish_bench();
    end

endmodule

// File: doc/vdf_iteration_sequencer.md
VDF_ITERATION_SEQUENCER -- requirements
Module: vdf_iteration_sequencer

Interface
REQ-001 SHALL have parameter MOD_LEN, default 1024, modulus width in bits.
REQ-002 SHALL have parameter WORD_LEN, default 16, coefficient word width.
REQ-003 SHALL have parameter NUM_ELEMENTS, default MOD_LEN/WORD_LEN+1, squarer coefficient count.
REQ-004 SHALL have parameter SQ_OUT_BITS, default NUM_ELEMENTS*WORD_LEN*2, squarer output width.
REQ-005 SHALL have parameter T_LEN, default 64, iteration-count width.
REQ-006 SHALL have parameter TIMEOUT, default 1024, max cycles between squarer valid pulses.
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port reset, input, 1; one clock; reset is synchronous and active-low.
REQ-009 SHALL have port job_valid, input, 1, host job request.
REQ-010 SHALL have port job_ready, output, 1, sequencer accepts job.
REQ-011 SHALL have port job_x, input, MOD_LEN, initial value.
REQ-012 SHALL have port job_t, input, T_LEN, requested squaring count.
REQ-013 SHALL have port abort, input, 1, cancel running job.
REQ-014 SHALL have port msq_reset, output, 1, active-high reset to squarer wrapper.
REQ-015 SHALL have port msq_start, output, 1, squarer start pulse.
REQ-016 SHALL have port msq_in, output, MOD_LEN, squarer input value.
REQ-017 SHALL have port msq_out, input, SQ_OUT_BITS, squarer result coefficients.
REQ-018 SHALL have port msq_valid, input, 1, one pulse per completed squaring.
REQ-019 SHALL have port res_valid, output, 1, result available.
REQ-020 SHALL have port res_ready, input, 1, host consumes result.
REQ-021 SHALL have port res_data, output, SQ_OUT_BITS, captured squarer output.
REQ-022 SHALL have port res_status, output, 2: 0 OK, 1 TIMEOUT, 2 ABORTED, 3 BAD_T.
REQ-023 SHALL have port iter_count, output, T_LEN, squarings completed in current job.

Function
REQ-024 SHALL implement states IDLE, ARM, LAUNCH, RUN, DONE.
REQ-025 SHALL assert job_ready only in IDLE; handshake occurs when job_valid and job_ready are both 1.
REQ-026 On handshake with job_t==0, SHALL go directly to DONE with res_status=3, res_data=0, squarer untouched.
REQ-027 On handshake with job_t!=0, SHALL register job_x into msq_in and job_t internally, clear iter_count, go to ARM.
REQ-028 SHALL drive msq_reset=1 in IDLE and DONE, 0 in ARM, LAUNCH, RUN (registered output).
REQ-029 ARM SHALL last exactly 1 cycle, then LAUNCH.
REQ-030 SHALL assert msq_start for exactly the single LAUNCH cycle, then enter RUN; msq_in held stable from ARM through LAUNCH.
REQ-031 In RUN, each msq_valid=1 cycle SHALL increment iter_count by 1.
REQ-032 When msq_valid=1 and iter_count==job_t-1, SHALL capture msq_out into res_data, set iter_count=job_t, res_status=0, go to DONE next cycle.
REQ-033 SHALL ignore msq_valid outside RUN.
REQ-034 In RUN, a watchdog SHALL count cycles since LAUNCH or the last msq_valid; reaching TIMEOUT without msq_valid SHALL go to DONE with res_status=1, res_data=0.
REQ-035 abort=1 in ARM, LAUNCH or RUN SHALL go to DONE with res_status=2, res_data=0; abort takes priority over same-cycle final msq_valid and over timeout.
REQ-036 abort in IDLE or DONE SHALL have no effect.
REQ-037 SHALL assert res_valid exactly while in DONE; res_data, res_status, iter_count held stable.
REQ-038 DONE with res_ready=1 SHALL return to IDLE next cycle; a new job cannot be accepted in the same cycle as res_ready.
REQ-039 iter_count SHALL not wrap; job_t==2^T_LEN-1 SHALL complete normally.

Reset
REQ-040 When reset==0 at a clock edge, SHALL enter IDLE regardless of state, including mid-RUN.
REQ-041 Reset values: job_ready=1 after first cycle in IDLE, msq_reset=1, msq_start=0, msq_in=0, res_valid=0, res_data=0, res_status=0, iter_count=0, watchdog=0.

Verification
REQ-042 job_x=3, job_t=5, squarer model valid every 4 cycles -> exactly one msq_start pulse, res_valid after 5th msq_valid, res_data = 5th output, iter_count=5, status 0.
REQ-043 job_t=0 -> res_valid next cycle, status 3, msq_start never asserted, msq_reset stays 1.
REQ-044 job_t=10, model stops after 3 valids, TIMEOUT=16 -> DONE 16 cycles after 3rd valid, status 1, iter_count=3.
REQ-045 job_t=4, abort asserted same cycle as 4th msq_valid -> status 2, res_data=0, iter_count=3.
REQ-046 reset=0 for one cycle mid-RUN at iter_count=2 -> IDLE, msq_reset=1, res_valid=0, job_ready=1; subsequent job_t=2 completes normally.
REQ-047 res_ready held 0 for 20 cycles in DONE -> res_valid and res_data stable, job_valid ignored, job_ready=0.
